// File: rtl/vaddubm_seq_if.sv
// Handshake and data bus for the sequential byte-lane vector adder.
// The slave modport is the unit's view and the master modport is the requester/consumer view.
// When VADDUBM_SAT_EN is defined, the bus also carries sat_mode (request side) and vsat (status side).
interface vaddubm_seq_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] vra;
    logic [LANES*LANE_W-1:0] vrb;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*LANE_W-1:0] vrt;
    logic [LANES-1:0]        vcarry;
`ifdef VADDUBM_SAT_EN
    logic                    sat_mode;
    logic                    vsat;
`endif

    modport slave (
        input  in_valid, vra, vrb, out_ready,
        output in_ready, out_valid, vrt, vcarry
`ifdef VADDUBM_SAT_EN
        , input sat_mode, output vsat
`endif
    );

    modport master (
        output in_valid, vra, vrb, out_ready,
        input  in_ready, out_valid, vrt, vcarry
`ifdef VADDUBM_SAT_EN
        , output sat_mode, input vsat
`endif
    );
endinterface

// File: rtl/vaddubm_seq.sv
// Sequential vector add unsigned byte modulo unit.
// The unit adds one LANE_W-bit lane per clock, starting at lane 0.
// It reports per-lane wrapped sums on vrt and per-lane carry-outs on vcarry.
// Optional macro VADDUBM_SAT_EN adds a captured sat_mode input and a sticky vsat flag.
// With saturation enabled, lanes that overflow write all-ones.
module vaddubm_seq #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    vaddubm_seq_if.slave  bus
);
    localparam int VEC_W = LANES * LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     lane_cnt;
    logic [VEC_W-1:0]     opa;
    logic [VEC_W-1:0]     opb;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [VEC_W-1:0]     vrt_q;
    logic [LANES-1:0]     vcarry_q;

    logic [LANE_W-1:0]    lane_a;
    logic [LANE_W-1:0]    lane_b;
    logic [LANE_W:0]      lane_sum;
    logic [LANE_W-1:0]    lane_res;
    int                   lane_base;

`ifdef VADDUBM_SAT_EN
    logic                 sat_q;
    logic                 vsat_q;
`endif

    // Select the lane being processed this cycle and form its sum (with saturation when enabled).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lane_base = int'(lane_cnt) * LANE_W;
        lane_a    = opa[lane_base +: LANE_W];
        lane_b    = opb[lane_base +: LANE_W];
        lane_sum  = {1'b0, lane_a} + {1'b0, lane_b};
        lane_res  = lane_sum[LANE_W-1:0];
`ifdef VADDUBM_SAT_EN
        if (sat_q && lane_sum[LANE_W]) begin
            lane_res = '1;
        end
`endif
    end

    // Operand capture at accept.
    // These registers are always overwritten before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath storage that is loaded before use needs no reset; leaving it out keeps the reset net small.
        if (state == IDLE && bus.in_valid) begin
            opa   <= bus.vra;
            opb   <= bus.vrb;
`ifdef VADDUBM_SAT_EN
            sat_q <= bus.sat_mode;
`endif
        end
    end

    // Control FSM with registered handshake outputs and lane-by-lane result accumulation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            lane_cnt    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            vrt_q       <= '0;
            vcarry_q    <= '0;
`ifdef VADDUBM_SAT_EN
            vsat_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vrt_q      <= '0;
                        vcarry_q   <= '0;
                        lane_cnt   <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    vrt_q[lane_base +: LANE_W] <= lane_res;
                    vcarry_q[lane_cnt]         <= lane_sum[LANE_W];
                    lane_cnt                   <= lane_cnt + 1'b1;
`ifdef VADDUBM_SAT_EN
                    if (sat_q && lane_sum[LANE_W]) begin
                        vsat_q <= 1'b1;
                    end
`endif
                    if (lane_cnt == LAST_LANE) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.vrt       = vrt_q;
    assign bus.vcarry    = vcarry_q;
`ifdef VADDUBM_SAT_EN
    assign bus.vsat      = vsat_q;
`endif

endmodule

// File: tb/tb_vaddubm_seq.sv
// Self-checking bench for vaddubm_seq.
// Expected results come from a lane-wise arithmetic model.
// Saturation checks are included when VADDUBM_SAT_EN is defined.
module tb_vaddubm_seq;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int VEC_W  = LANES * LANE_W;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_vsat = 1'b0;

    vaddubm_seq_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    vaddubm_seq #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Reference: each lane is an independent unsigned add; results are mod 256 or clamped to 255.
    function automatic void model(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input bit sat,
                                  output logic [VEC_W-1:0] r, output logic [LANES-1:0] c, output bit s);
        int ai, bi, sum;
        r = '0;
        c = '0;
        s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            ai   = int'((a >> (8 * i)) & 32'hFF);
            bi   = int'((b >> (8 * i)) & 32'hFF);
            sum  = ai + bi;
            c[i] = (sum > 255);
            if (sat && sum > 255) begin
                r = r | (32'hFF << (8 * i));
                s = 1'b1;
            end else begin
                r = r | (VEC_W'(sum % 256) << (8 * i));
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sat(input bit sat);
`ifdef VADDUBM_SAT_EN
        bus.sat_mode = sat;
`else
        if (sat) $display("note: saturation requested in a build without it");
`endif
    endtask

    // Waits (bounded) for in_ready, then presents operands for exactly one accept edge.
    task automatic accept(input string tag, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input bit sat);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", tag, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.vra      = a;
        bus.vrb      = b;
        set_sat(sat);
        step();
        bus.in_valid = 1'b0;
        bus.vra      = $urandom;
        bus.vrb      = $urandom;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready_after_accept: got %b required 0", tag, bus.in_ready);
        end
    endtask

    // Runs one operation end-to-end: checks latency, result, and handshake release.
    task automatic run_op(input string tag, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                          input bit sat, input int hold);
        logic [VEC_W-1:0] er;
        logic [LANES-1:0] ec;
        bit               es;
        model(a, b, sat, er, ec, es);
        accept(tag, a, b, sat);
        for (int k = 1; k <= LANES; k++) begin
            step();
            n_checks++;
            if (bus.out_valid !== (k == LANES)) begin
                n_fail++;
                $display("FAIL %s out_valid_latency edge+%0d: got %b required %b", tag, k, bus.out_valid, (k == LANES));
            end
        end
        n_checks++;
        if (bus.vrt !== er) begin
            n_fail++;
            $display("FAIL %s vrt: got %h required %h", tag, bus.vrt, er);
        end
        n_checks++;
        if (bus.vcarry !== ec) begin
            n_fail++;
            $display("FAIL %s vcarry: got %b required %b", tag, bus.vcarry, ec);
        end
`ifdef VADDUBM_SAT_EN
        exp_vsat = exp_vsat | es;
        n_checks++;
        if (bus.vsat !== exp_vsat) begin
            n_fail++;
            $display("FAIL %s vsat: got %b required %b", tag, bus.vsat, exp_vsat);
        end
`endif
        repeat (hold) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", tag, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_vsat = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        n_checks++;
        if (bus.vrt !== '0 || bus.vcarry !== '0) begin
            n_fail++;
            $display("FAIL reset_data: vrt=%h vcarry=%b required 0/0", bus.vrt, bus.vcarry);
        end
`ifdef VADDUBM_SAT_EN
        n_checks++;
        if (bus.vsat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vsat: got %b required 0", bus.vsat);
        end
`endif
    endtask

    task automatic test_basic();
        run_op("basic", 32'h01020304, 32'h10203040, 1'b0, 0);
        n_checks++;
        if (bus.vrt !== 32'h11223344) begin
            n_fail++;
            $display("FAIL basic_const: vrt=%h required 11223344", bus.vrt);
        end
    endtask

    task automatic test_carry_isolation();
        run_op("carry_all", 32'hFFFF80FF, 32'h01018001, 1'b0, 1);
        n_checks++;
        if (bus.vrt !== 32'h00000000 || bus.vcarry !== 4'b1111) begin
            n_fail++;
            $display("FAIL carry_all_const: vrt=%h vcarry=%b required 00000000/1111", bus.vrt, bus.vcarry);
        end
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] er;
        logic [LANES-1:0] ec;
        bit               es;
        logic [VEC_W-1:0] a = $urandom;
        logic [VEC_W-1:0] b = $urandom;
        model(a, b, 1'b0, er, ec, es);
        accept("bp", a, b, 1'b0);
        repeat (LANES) step();
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'($urandom);
            bus.vra      = $urandom;
            bus.vrb      = $urandom;
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.vrt !== er || bus.vcarry !== ec) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: ov=%b ir=%b vrt=%h vc=%b required 1/0/%h/%b",
                         k, bus.out_valid, bus.in_ready, bus.vrt, bus.vcarry, er, ec);
            end
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        accept("rst_mid", 32'h11111111, 32'h22222222, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_vsat = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.vrt !== '0 || bus.vcarry !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_state: ir=%b ov=%b vrt=%h vc=%b required 1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.vrt, bus.vcarry);
        end
        run_op("after_rst", 32'h000000FF, 32'h00000001, 1'b0, 0);
        n_checks++;
        if (bus.vrt !== 32'h00000000 || bus.vcarry !== 4'b0001) begin
            n_fail++;
            $display("FAIL after_rst_const: vrt=%h vcarry=%b required 00000000/0001", bus.vrt, bus.vcarry);
        end
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] exp_r[$];
        logic [LANES-1:0] exp_c[$];
        logic [VEC_W-1:0] er;
        logic [LANES-1:0] ec;
        bit               es;
        bit               ready_before;
        bit               prev_ov = 1'b0;
        int               last_acc = -1;
        int               n_res = 0;
        int               waited = 0;
        set_sat(1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.vra       = $urandom;
        bus.vrb       = $urandom;
        for (int cyc = 0; cyc < 40; cyc++) begin
            ready_before = bus.in_ready;
            model(bus.vra, bus.vrb, 1'b0, er, ec, es);
            step();
            if (ready_before) begin
                exp_r.push_back(er);
                exp_c.push_back(ec);
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != LANES + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d cycles required %0d", cyc - last_acc, LANES + 2);
                    end
                end
                last_acc = cyc;
                bus.vra  = $urandom;
                bus.vrb  = $urandom;
            end
            if (bus.out_valid === 1'b1) begin
                n_res++;
                n_checks++;
                if (prev_ov) begin
                    n_fail++;
                    $display("FAIL b2b_pulse: out_valid high for more than one cycle at cycle %0d", cyc);
                end
                n_checks++;
                if (exp_r.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious: result with no accepted operands, vrt=%h", bus.vrt);
                end else begin
                    er = exp_r.pop_front();
                    ec = exp_c.pop_front();
                    if (bus.vrt !== er || bus.vcarry !== ec) begin
                        n_fail++;
                        $display("FAIL b2b_result: vrt=%h vc=%b required %h/%b", bus.vrt, bus.vcarry, er, ec);
                    end
                end
            end
            prev_ov = (bus.out_valid === 1'b1);
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (n_res < 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required at least 5", n_res);
        end
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit sat;
        for (int i = 0; i < 10; i++) begin
`ifdef VADDUBM_SAT_EN
            sat = 1'($urandom);
`else
            sat = 1'b0;
`endif
            run_op("random", $urandom, $urandom, sat, int'($urandom_range(0, 2)));
        end
    endtask

`ifdef VADDUBM_SAT_EN
    task automatic test_sat();
        test_reset();
        run_op("sat_off_wrap", 32'hF0108000, 32'h20F08001, 1'b0, 0);
        run_op("sat_on", 32'hF0108000, 32'h20F08001, 1'b1, 0);
        n_checks++;
        if (bus.vrt !== 32'hFFFFFF01 || bus.vcarry !== 4'b1110 || bus.vsat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_const: vrt=%h vc=%b vsat=%b required FFFFFF01/1110/1",
                     bus.vrt, bus.vcarry, bus.vsat);
        end
        run_op("sat_sticky", 32'h01010101, 32'h02020202, 1'b1, 0);
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.vra       = '0;
        bus.vrb       = '0;
        set_sat(1'b0);
        test_reset();
        test_basic();
        test_carry_isolation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef VADDUBM_SAT_EN
        test_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
